// File: rtl/imem_responder.sv
// imem_responder: memory end of the fetch-stage instruction interface.
// Word-organised store with a backdoor load port, address range/alignment
// checking and a programmable response latency (0 = combinational).
//
// Handshake: imem_read is a level request that the fetch stage holds,
// together with imem_addr, until it has seen a response. imem_valid or
// imem_error is asserted only while the request and the address that was
// captured are both still being presented. The two are never asserted in
// the same cycle. Changing the address restarts the lookup, and dropping
// imem_read abandons it. A response is held for as long as the request
// stays unchanged.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   imem_addr,
  input  logic          imem_read,
  output logic [31:0]   imem_data,
  output logic          imem_valid,
  output logic          imem_error,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          busy,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // One past the last valid byte address, kept 33 bits wide so a window
  // that ends at the top of the address space does not wrap.
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        enter_resp;
  logic        hit;
  logic        l0_valid;

  function automatic logic is_bad(input logic [31:0] a);
    return (|a[1:0]) || ({1'b0, a} < {1'b0, BASE_ADDR}) || ({1'b0, a} >= LIMIT);
  endfunction

  function automatic logic [AW-1:0] idx_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  // Backdoor load port; the store itself is never reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Request tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= BASE_ADDR;
      data_q  <= NOP_WORD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: capture, count down wait states, hold the response.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    if (LATENCY != 0) begin
      unique case (state_q)
        IDLE: begin
          if (imem_read) begin
            addr_d = imem_addr;
            err_d  = is_bad(imem_addr);
            if (LATENCY == 1) begin
              state_d    = RESP;
              enter_resp = 1'b1;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (!imem_read) begin
            state_d = IDLE;
          end else if (imem_addr != addr_q) begin
            addr_d  = imem_addr;
            err_d   = is_bad(imem_addr);
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else if (cnt_q == 4'd0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (!imem_read) begin
            state_d = IDLE;
          end else if (imem_addr != addr_q) begin
            addr_d = imem_addr;
            err_d  = is_bad(imem_addr);
            if (LATENCY == 1) begin
              state_d    = RESP;
              enter_resp = 1'b1;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // The word is fetched for the address being held into RESP. A load to
      // the same word in that cycle takes priority over the stored value.
      if (enter_resp) begin
        if (load_en && (load_addr == idx_of(addr_d))) begin
          data_d = load_data;
        end else begin
          data_d = mem[idx_of(addr_d)];
        end
      end
    end
  end

  // Response outputs: direct lookup at zero latency, otherwise decoded from RESP.
  always_comb begin
    hit      = (state_q == RESP) && imem_read && (imem_addr == addr_q);
    l0_valid = imem_read && !is_bad(imem_addr);
    if (LATENCY == 0) begin
      imem_valid = l0_valid;
      imem_error = imem_read && is_bad(imem_addr);
      imem_data  = l0_valid ? mem[idx_of(imem_addr)] : NOP_WORD;
    end else begin
      imem_valid = hit && !err_q;
      imem_error = hit && err_q;
      imem_data  = (hit && !err_q) ? data_q : NOP_WORD;
    end
  end

  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: four instances (latency 0..3) share the
// request and load inputs; each table row names the instance it checks.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;

  logic [31:0] o_data  [4];
  logic        o_valid [4];
  logic        o_error [4];
  logic        o_busy  [4];
  logic [1:0]  o_state [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          lat;
    logic        rd;
    logic [31:0] addr;
    logic        ld;
    logic [3:0]  laddr;
    logic [31:0] ldata;
    logic        ev;
    logic        ee;
    logic [31:0] ed;
    logic        eb;
  } vec_t;

  vec_t vecs[$];

  imem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_read(imem_read),
    .imem_data(o_data[0]), .imem_valid(o_valid[0]), .imem_error(o_error[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(o_busy[0]), .dbg_state_o(o_state[0]));

  imem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_read(imem_read),
    .imem_data(o_data[1]), .imem_valid(o_valid[1]), .imem_error(o_error[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(o_busy[1]), .dbg_state_o(o_state[1]));

  imem_responder #(.DEPTH_WORDS(16), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_read(imem_read),
    .imem_data(o_data[2]), .imem_valid(o_valid[2]), .imem_error(o_error[2]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(o_busy[2]), .dbg_state_o(o_state[2]));

  imem_responder #(.DEPTH_WORDS(16), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_read(imem_read),
    .imem_data(o_data[3]), .imem_valid(o_valid[3]), .imem_error(o_error[3]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(o_busy[3]), .dbg_state_o(o_state[3]));

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int lat, input logic ev, input logic ee,
                         input logic [31:0] ed, input logic eb);
    chk($sformatf("%s L%0d valid", tag, lat), 32'(o_valid[lat]), 32'(ev));
    chk($sformatf("%s L%0d error", tag, lat), 32'(o_error[lat]), 32'(ee));
    chk($sformatf("%s L%0d data", tag, lat), o_data[lat], ed);
    chk($sformatf("%s L%0d busy", tag, lat), 32'(o_busy[lat]), 32'(eb));
  endtask

  function automatic void add(int lat, logic rd, logic [31:0] a, logic ld, logic [3:0] la,
                              logic [31:0] lv, logic ev, logic ee, logic [31:0] ed, logic eb);
    vec_t v;
    v.lat = lat; v.rd = rd; v.addr = a; v.ld = ld; v.laddr = la; v.ldata = lv;
    v.ev = ev; v.ee = ee; v.ed = ed; v.eb = eb;
    vecs.push_back(v);
  endfunction

  // Driver: apply a request just after the rising edge.
  task automatic drive(input logic rd, input logic [31:0] a, input logic ld,
                       input logic [3:0] la, input logic [31:0] lv);
    imem_read = rd; imem_addr = a; load_en = ld; load_addr = la; load_data = lv;
  endtask

  // Invariant: no instance ever reports valid and error together.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (o_valid[k] && o_error[k]) begin
          errors++;
          $display("FAIL valid_and_error L%0d: got both asserted expected exclusive", k);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'd0, 32'h0);

    // Preload (checks L1 idle while loading).
    add(1, 0, 32'h0, 1, 4'd0, 32'h0050_0093, 0, 0, NOP, 0);
    add(1, 0, 32'h0, 1, 4'd1, 32'h00A0_0113, 0, 0, NOP, 0);
    add(1, 0, 32'h0, 1, 4'd2, 32'h1111_1111, 0, 0, NOP, 0);
    add(1, 0, 32'h0, 1, 4'd3, 32'h3333_3333, 0, 0, NOP, 0);
    // L=1: capture, hold, sequential step to 0x4.
    add(1, 1, 32'h0, 0, 4'd0, 32'h0, 0, 0, NOP, 0);
    add(1, 1, 32'h0, 0, 4'd0, 32'h0, 1, 0, 32'h0050_0093, 1);
    add(1, 1, 32'h0, 0, 4'd0, 32'h0, 1, 0, 32'h0050_0093, 1);
    add(1, 1, 32'h0, 0, 4'd0, 32'h0, 1, 0, 32'h0050_0093, 1);
    add(1, 1, 32'h4, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(1, 1, 32'h4, 0, 4'd0, 32'h0, 1, 0, 32'h00A0_0113, 1);
    add(1, 0, 32'h4, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(1, 0, 32'h4, 0, 4'd0, 32'h0, 0, 0, NOP, 0);
    // L=2: misaligned, then one past the end of the window.
    add(2, 1, 32'h2, 0, 4'd0, 32'h0, 0, 0, NOP, 0);
    add(2, 1, 32'h2, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(2, 1, 32'h2, 0, 4'd0, 32'h0, 0, 1, NOP, 1);
    add(2, 1, 32'h40, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(2, 1, 32'h40, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(2, 1, 32'h40, 0, 4'd0, 32'h0, 0, 1, NOP, 1);
    add(2, 0, 32'h40, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(2, 0, 32'h40, 0, 4'd0, 32'h0, 0, 0, NOP, 0);
    // L=3: address switch during wait restarts the full latency.
    add(3, 1, 32'h8, 0, 4'd0, 32'h0, 0, 0, NOP, 0);
    add(3, 1, 32'hC, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(3, 1, 32'hC, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(3, 1, 32'hC, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(3, 1, 32'hC, 0, 4'd0, 32'h0, 1, 0, 32'h3333_3333, 1);
    add(3, 0, 32'hC, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(3, 0, 32'hC, 0, 4'd0, 32'h0, 0, 0, NOP, 0);
    // L=3: read dropped during wait aborts.
    add(3, 1, 32'h8, 0, 4'd0, 32'h0, 0, 0, NOP, 0);
    add(3, 0, 32'h8, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(3, 0, 32'h8, 0, 4'd0, 32'h0, 0, 0, NOP, 0);
    add(3, 0, 32'h8, 0, 4'd0, 32'h0, 0, 0, NOP, 0);
    // L=1: load in the capture cycle is written through to the response.
    add(1, 1, 32'hC, 1, 4'd3, 32'hDEAD_BEEF, 0, 0, NOP, 0);
    add(1, 1, 32'hC, 0, 4'd0, 32'h0, 1, 0, 32'hDEAD_BEEF, 1);
    add(1, 0, 32'hC, 0, 4'd0, 32'h0, 0, 0, NOP, 1);
    add(1, 0, 32'hC, 0, 4'd0, 32'h0, 0, 0, NOP, 0);
    // L=0: combinational lookup and checks; same-cycle load not bypassed.
    add(0, 1, 32'h4, 0, 4'd0, 32'h0, 1, 0, 32'h00A0_0113, 0);
    add(0, 1, 32'h5, 0, 4'd0, 32'h0, 0, 1, NOP, 0);
    add(0, 0, 32'h4, 0, 4'd0, 32'h0, 0, 0, NOP, 0);
    add(0, 1, 32'h40, 0, 4'd0, 32'h0, 0, 1, NOP, 0);
    add(0, 1, 32'h8, 1, 4'd2, 32'h2222_2222, 1, 0, 32'h1111_1111, 0);
    add(0, 1, 32'h8, 0, 4'd0, 32'h0, 1, 0, 32'h2222_2222, 0);
    add(0, 0, 32'h8, 0, 4'd0, 32'h0, 0, 0, NOP, 0);

    // Reset state, checked while reset is held.
    #3;
    for (int k = 0; k < 4; k++) begin
      chk_out("reset", k, 0, 0, NOP, 0);
      chk($sformatf("reset L%0d state", k), 32'(o_state[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].rd, vecs[i].addr, vecs[i].ld, vecs[i].laddr, vecs[i].ldata);
      @(negedge clk);
      chk_out($sformatf("row%0d", i), vecs[i].lat, vecs[i].ev, vecs[i].ee, vecs[i].ed, vecs[i].eb);
    end

    // Asynchronous reset in the middle of a request.
    @(posedge clk); #1;
    drive(1'b1, 32'h8, 1'b0, 4'd0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_out("pre_rst", 1, 1, 0, 32'h2222_2222, 1);
    chk_out("pre_rst", 3, 0, 0, NOP, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_out("in_rst", 1, 0, 0, NOP, 0);
    chk_out("in_rst", 3, 0, 0, NOP, 0);
    @(posedge clk); #1;
    imem_read = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_out($sformatf("post_rst%0d", c), 1, 0, 0, NOP, 0);
      chk_out($sformatf("post_rst%0d", c), 3, 0, 0, NOP, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
